// File: rtl/pifo_driver.sv
// pifo_driver: ingress descriptor FIFO and insert gating, egress remove/holdoff and output register for a skip-list PIFO
// Ports: clk/rst (sync, active-high); in_* valid/ready ingress stream; out_* valid/ready egress stream;
// pifo_insert/pifo_rank_in/pifo_meta_in insert side; pifo_busy/pifo_full PIFO status;
// pifo_remove/pifo_rank_out/pifo_meta_out/pifo_valid_out remove side; pifo_count tracked PIFO occupancy.
module pifo_driver #(
    parameter int L2_MAX_SIZE   = 5,
    parameter int RANK_WIDTH    = 10,
    parameter int META_WIDTH    = 20,
    parameter int L2_FIFO_DEPTH = 2,
    parameter int REMOVE_GAP    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RANK_WIDTH-1:0]  in_rank,
    input  logic [META_WIDTH-1:0]  in_meta,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RANK_WIDTH-1:0]  out_rank,
    output logic [META_WIDTH-1:0]  out_meta,
    output logic                   pifo_insert,
    output logic [RANK_WIDTH-1:0]  pifo_rank_in,
    output logic [META_WIDTH-1:0]  pifo_meta_in,
    input  logic                   pifo_busy,
    input  logic                   pifo_full,
    output logic                   pifo_remove,
    input  logic [RANK_WIDTH-1:0]  pifo_rank_out,
    input  logic [META_WIDTH-1:0]  pifo_meta_out,
    input  logic                   pifo_valid_out,
    output logic [L2_MAX_SIZE:0]   pifo_count
);
    localparam int DEPTH = 1 << L2_FIFO_DEPTH;
    localparam int CW = L2_MAX_SIZE + 1;
    localparam int FW = L2_FIFO_DEPTH + 1;
    typedef enum logic {RUN, HOLD} state_t;
    state_t state;
    logic [RANK_WIDTH+META_WIDTH-1:0] mem [DEPTH];
    logic [L2_FIFO_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] fifo_cnt, fifo_cnt_nxt;
    logic [3:0] holdoff;
    logic push;
    assign push = in_valid & in_ready;
    // Occupancy cap keeps pifo_count from wrapping even if the PIFO under-reports full
    assign pifo_insert = ~rst & (fifo_cnt != '0) & ~pifo_busy & ~pifo_full & (pifo_count < CW'(1 << L2_MAX_SIZE));
    assign {pifo_rank_in, pifo_meta_in} = mem[rd_ptr];
    assign pifo_remove = ~rst & (state == RUN) & pifo_valid_out & (~out_valid | out_ready);
    assign fifo_cnt_nxt = fifo_cnt + FW'(push) - FW'(pifo_insert);
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_rank, in_meta};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            in_ready   <= 1'b0;
            pifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pifo_insert)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt   <= fifo_cnt_nxt;
            // Registered from the next depth so in_ready has no combinational path from in_valid
            in_ready   <= fifo_cnt_nxt != FW'(DEPTH);
            pifo_count <= pifo_count + CW'(pifo_insert) - CW'(pifo_remove);
        end
    end
    // HOLD masks the PIFO's stale head for REMOVE_GAP cycles after each remove
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            holdoff   <= '0;
            out_valid <= 1'b0;
            out_rank  <= '0;
            out_meta  <= '0;
        end else if (pifo_remove) begin
            state     <= HOLD;
            holdoff   <= 4'(REMOVE_GAP);
            out_valid <= 1'b1;
            out_rank  <= pifo_rank_out;
            out_meta  <= pifo_meta_out;
        end else begin
            if (state == HOLD) begin
                holdoff <= holdoff - 1'b1;
                if (holdoff == 4'd1)
                    state <= RUN;
            end
            if (out_valid & out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pifo_driver.sv
// tb_pifo_driver: directed + random checks of pifo_driver against a sorted-queue PIFO and stream-level expectations
module tb_pifo_driver;
    typedef struct packed {logic [9:0] r; logic [19:0] m;} ent_t;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [9:0] in_rank = 0, out_rank, pifo_rank_in;
    logic [19:0] in_meta = 0, out_meta, pifo_meta_in;
    logic pifo_insert, pifo_busy = 0, pifo_full = 0, pifo_remove, pifo_valid_out;
    logic [9:0] pifo_rank_out;
    logic [19:0] pifo_meta_out;
    logic [5:0] pifo_count;
    logic head_en = 0, hv = 0;
    ent_t pq[$], ins_acc[$], outs[$];
    int rem_cyc[$];
    int cyc = 0, n_cmp = 0, n_err = 0, seq = 1;

    pifo_driver dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rank(in_rank), .in_meta(in_meta),
        .out_valid(out_valid), .out_ready(out_ready), .out_rank(out_rank), .out_meta(out_meta),
        .pifo_insert(pifo_insert), .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
        .pifo_busy(pifo_busy), .pifo_full(pifo_full), .pifo_remove(pifo_remove),
        .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out), .pifo_valid_out(pifo_valid_out),
        .pifo_count(pifo_count)
    );

    always #5 clk = ~clk;
    assign pifo_valid_out = head_en & hv;

    // Behavioural PIFO: queue kept in rank order, ties in arrival order; head presented after each edge
    always @(posedge clk) begin
        ent_t e;
        int k;
        if (rst) begin
            pq.delete();
        end else begin
            if (in_valid && in_ready) ins_acc.push_back({in_rank, in_meta});
            if (out_valid && out_ready) outs.push_back({out_rank, out_meta});
            if (pifo_remove) begin
                pq.delete(0);
                rem_cyc.push_back(cyc);
            end
            if (pifo_insert) begin
                e = {pifo_rank_in, pifo_meta_in};
                k = 0;
                while (k < pq.size() && pq[k].r <= e.r) k++;
                pq.insert(k, e);
            end
        end
        cyc++;
        hv <= pq.size() != 0;
        pifo_rank_out <= pq.size() != 0 ? pq[0].r : 10'd0;
        pifo_meta_out <= pq.size() != 0 ? pq[0].m : 20'd0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [9:0] r, input logic [19:0] m);
        int t = 0;
        in_valid = 1; in_rank = r; in_meta = m;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("push_timeout", 1, 0);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic drain(input int n);
        head_en = 1; out_ready = 1; pifo_busy = 0; pifo_full = 0; in_valid = 0;
        tick(n);
        chk("drain_count", pifo_count, 0);
        chk("drain_out_valid", out_valid, 0);
    endtask

    // Expected stream: accepted descriptors sorted by rank (meta rises with arrival, so ties keep arrival order)
    task automatic cmp_outs(input string tag, input bit ordered);
        ent_t e[$];
        ent_t o[$];
        e = ins_acc; e.sort();
        o = outs;
        if (!ordered) o.sort();
        chk({tag, "_len"}, o.size(), e.size());
        for (int i = 0; i < o.size() && i < e.size(); i++) chk({tag, "_item"}, o[i], e[i]);
        ins_acc.delete(); outs.delete();
    endtask

    initial begin
        int acc;
        bit accepted, acc_prev;
        // Reset state
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", pifo_count, 0);
        chk("rst_insert", pifo_insert, 0);
        chk("rst_remove", pifo_remove, 0);
        rst = 0;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // Basic ordering 7,3,5 -> 3,5,7
        out_ready = 1;
        push(7, 20'h11); push(3, 20'h22); push(5, 20'h33);
        tick(3);
        chk("t2_count3", pifo_count, 3);
        head_en = 1;
        tick(15);
        chk("t2_len", outs.size(), 3);
        if (outs.size() == 3) begin
            chk("t2_o0", outs[0], {10'd3, 20'h22});
            chk("t2_o1", outs[1], {10'd5, 20'h33});
            chk("t2_o2", outs[2], {10'd7, 20'h11});
        end
        chk("t2_count0", pifo_count, 0);
        ins_acc.delete(); outs.delete();

        // Busy stall: FIFO takes 4, no inserts; release drains 4 back-to-back
        head_en = 0; pifo_busy = 1; acc = 0;
        in_valid = 1; in_rank = 10'($urandom % 16); in_meta = 20'(seq++);
        for (int i = 0; i < 10; i++) begin
            #1 chk("t3_no_insert", pifo_insert, 0);
            accepted = in_ready;
            if (accepted) acc++;
            @(negedge clk);
            if (accepted) begin in_rank = 10'($urandom % 16); in_meta = 20'(seq++); end
        end
        in_valid = 0;
        chk("t3_accepted", acc, 4);
        chk("t3_in_ready_low", in_ready, 0);
        pifo_busy = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t3_insert_run", pifo_insert, 1);
            tick();
        end
        chk("t3_fifo_empty", pifo_insert, 0);
        push(10'($urandom % 16), 20'(seq++));
        push(10'($urandom % 16), 20'(seq++));
        tick(3);
        chk("t3_count6", pifo_count, 6);
        drain(40);
        cmp_outs("t3_out", 1);

        // Capacity cap at 32 with pifo_full low
        head_en = 0; out_ready = 0;
        for (int i = 0; i < 36; i++) push(10'($urandom % 64), 20'(seq++));
        tick(4);
        chk("t4_count32", pifo_count, 32);
        chk("t4_no_insert", pifo_insert, 0);
        chk("t4_fifo_full", in_ready, 0);
        drain(160);
        cmp_outs("t4_out", 0);

        // Egress backpressure and remove spacing
        head_en = 0; out_ready = 1;
        push(1, 20'(seq++)); push(2, 20'(seq++)); push(3, 20'(seq++));
        tick(3);
        chk("t5_count3", pifo_count, 3);
        out_ready = 0; head_en = 1;
        #1 chk("t5_first_remove", pifo_remove, 1);
        tick(5);
        chk("t5_held_valid", out_valid, 1);
        chk("t5_no_remove", pifo_remove, 0);
        out_ready = 1;
        #1 chk("t5_remove_on_ready", pifo_remove, 1);
        tick();
        chk("t5_reload_valid", out_valid, 1);
        chk("t5_reload_rank", out_rank, 2);
        chk("t5_gap1", pifo_remove, 0);
        tick();
        chk("t5_gap2", pifo_remove, 0);
        tick();
        chk("t5_gap3", pifo_remove, 1);
        drain(20);
        cmp_outs("t5_out", 1);

        // Simultaneous insert/remove at count 4, full gating, FIFO push+pop at depth 2
        head_en = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) push(10'($urandom % 16), 20'(seq++));
        tick(3);
        chk("t6_count4", pifo_count, 4);
        pifo_full = 1;
        push(10'($urandom % 16), 20'(seq++));
        #1 chk("t6_full_blocks", pifo_insert, 0);
        pifo_full = 0; head_en = 1;
        #1 chk("t6_both_ins", pifo_insert, 1);
        chk("t6_both_rem", pifo_remove, 1);
        tick();
        head_en = 0;
        chk("t6_count_same", pifo_count, 4);
        pifo_busy = 1;
        push(10'($urandom % 16), 20'(seq++));
        push(10'($urandom % 16), 20'(seq++));
        in_rank = 10'($urandom % 16); in_meta = 20'(seq++);
        in_valid = 1; pifo_busy = 0;
        #1 chk("t6_pp_insert", pifo_insert, 1);
        chk("t6_pp_ready", in_ready, 1);
        tick();
        pifo_busy = 1;
        in_rank = 10'($urandom % 16); in_meta = 20'(seq++);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            accepted = in_ready;
            if (accepted) acc++;
            @(negedge clk);
            if (accepted) begin in_rank = 10'($urandom % 16); in_meta = 20'(seq++); end
        end
        in_valid = 0;
        chk("t6_depth_kept", acc, 2);
        drain(60);
        cmp_outs("t6_out", 0);

        // Random traffic: occupancy tracks the PIFO, stream conserved, removes spaced
        rem_cyc.delete();
        head_en = 1; acc_prev = 0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc_prev) begin
                in_valid = $urandom % 2; in_rank = 10'($urandom % 16); in_meta = 20'(seq++);
            end
            out_ready = ($urandom % 4) != 0;
            pifo_busy = ($urandom % 4) == 0;
            #1 chk("rnd_remove_ok", pifo_remove & out_valid & ~out_ready, 0);
            acc_prev = in_valid && in_ready;
            @(negedge clk);
            chk("rnd_count", pifo_count, pq.size());
        end
        in_valid = 0;
        drain(200);
        cmp_outs("rnd_out", 0);
        for (int k = 1; k < rem_cyc.size(); k++) chk("rnd_gap", rem_cyc[k] - rem_cyc[k-1] >= 3, 1);

        // Reset mid-traffic
        for (int i = 0; i < 30; i++) begin
            in_valid = $urandom % 2; in_rank = 10'($urandom % 16); in_meta = 20'(seq++);
            out_ready = $urandom % 2;
            tick();
        end
        rst = 1;
        tick();
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_rank", out_rank, 0);
        chk("mrst_out_meta", out_meta, 0);
        chk("mrst_count", pifo_count, 0);
        chk("mrst_insert", pifo_insert, 0);
        chk("mrst_remove", pifo_remove, 0);
        tick(2);
        rst = 0; in_valid = 0; pifo_busy = 0; out_ready = 1;
        tick();
        chk("mrst_rel_ready", in_ready, 1);
        tick(3);
        chk("mrst_fifo_discarded", pifo_count, 0);
        chk("mrst_out_clear", out_valid, 0);
        ins_acc.delete(); outs.delete();
        push(9, 20'h5a5a5);
        tick(6);
        chk("mrst_run_len", outs.size(), 1);
        if (outs.size() == 1) chk("mrst_run_item", outs[0], {10'd9, 20'h5a5a5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
